// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and encodings for the CPU controller and datapath.
// Holds controller states, instruction classes, opcode/op and vsel codes.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_ALU,
    S_WRITE_REG
  } state_t;

  typedef enum logic [2:0] {
    IC_NOP,
    IC_MOV_IMM,
    IC_MOV_REG,
    IC_ADD,
    IC_CMP,
    IC_AND,
    IC_MVN
  } iclass_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational split of the IR into fields and a class.
// ir in; iclass, rn/rd/rm, sh, alu_op, sximm8/sximm5 out.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output iclass_t     iclass,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  sh,
  output logic [1:0]  alu_op,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  logic [2:0] opcode;
  logic [1:0] op;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign alu_op = (opcode == OPC_ALU) ? op : 2'b00;
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    iclass = IC_NOP;
    unique case (1'b1)
      (opcode == OPC_MOV && op == OP_MOV_IMM): iclass = IC_MOV_IMM;
      (opcode == OPC_MOV && op == OP_MOV_REG): iclass = IC_MOV_REG;
      (opcode == OPC_ALU && op == OP_ADD):     iclass = IC_ADD;
      (opcode == OPC_ALU && op == OP_CMP):     iclass = IC_CMP;
      (opcode == OPC_ALU && op == OP_AND):     iclass = IC_AND;
      (opcode == OPC_ALU && op == OP_MVN):     iclass = IC_MVN;
      default:                                 iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/cpu_controller.sv
// cpu_controller: instruction register and Moore FSM for the datapath.
// in/load/s in; w, vsel, load strobes, selects, fields, immediates out.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic        s,
  output logic        w,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        write,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      state;
  state_t      state_n;
  logic [15:0] ir;
  iclass_t     iclass;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;

  instr_decoder u_dec (
    .ir     (ir),
    .iclass (iclass),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .sh     (shift),
    .alu_op (ALUop),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      S_WAIT: if (s) state_n = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (iclass == IC_MOV_IMM):
            state_n = S_WRITE_IMM;
          (iclass == IC_ADD ||
           iclass == IC_CMP ||
           iclass == IC_AND):
            state_n = S_GET_A;
          (iclass == IC_MOV_REG ||
           iclass == IC_MVN):
            state_n = S_GET_B;
          default:
            state_n = S_WAIT;
        endcase
      end
      S_GET_A: state_n = S_GET_B;
      S_GET_B: state_n = S_ALU;
      S_ALU:
        state_n = (iclass == IC_CMP) ? S_WAIT : S_WRITE_REG;
      default: state_n = S_WAIT;
    endcase
  end

  // The IR is only writable while idle so a busy instruction
  // always sees stable fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_WAIT;
      ir    <= '0;
    end else begin
      state <= state_n;
      if (load && state == S_WAIT) ir <= in;
    end
  end

  assign readnum  = (state == S_GET_A) ? rn : rm;
  assign writenum = (state == S_WRITE_IMM) ? rn : rd;

  always_comb begin
    w     = 1'b0;
    vsel  = VSEL_C;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    write = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    unique case (state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        vsel  = VSEL_IMM;
        write = 1'b1;
      end
      S_GET_A: loada = 1'b1;
      S_GET_B: loadb = 1'b1;
      S_ALU: begin
        loadc = 1'b1;
        loads = (iclass == IC_CMP);
        // MOV reg passes B through the ALU as 0 + B
        asel  = (iclass == IC_MOV_REG);
      end
      S_WRITE_REG: write = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb_cpu_controller: vector table, hand sequences and random run
// checked against a per-instruction cycle script model.
module tb_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] in = '0;
  logic        load = 1'b0;
  logic        s = 1'b0;
  logic        w;
  logic [1:0]  vsel;
  logic        loada, loadb, loadc, loads, write, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic [2:0]  readnum, writenum;
  logic [15:0] sximm8, sximm5;

  always #5 clk = ~clk;

  cpu_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .load     (load),
    .s        (s),
    .w        (w),
    .vsel     (vsel),
    .loada    (loada),
    .loadb    (loadb),
    .loadc    (loadc),
    .loads    (loads),
    .write    (write),
    .asel     (asel),
    .bsel     (bsel),
    .shift    (shift),
    .ALUop    (ALUop),
    .readnum  (readnum),
    .writenum (writenum),
    .sximm8   (sximm8),
    .sximm5   (sximm5)
  );

  typedef struct packed {
    logic        w;
    logic [1:0]  vsel;
    logic        loada, loadb, loadc, loads, write, asel, bsel;
    logic [1:0]  shift, aluop;
    logic [2:0]  readnum, writenum;
    logic [15:0] sximm8, sximm5;
  } obs_t;

  obs_t act;
  assign act = {w, vsel, loada, loadb, loadc, loads, write, asel,
                bsel, shift, ALUop, readnum, writenum, sximm8, sximm5};

  typedef struct {
    logic [15:0] ir;
    int busy, writes, wnum, aop, lds, asl, lda;
  } vec_t;

  int   n_chk = 0;
  int   n_fail = 0;
  obs_t exp_q[$];

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic string mnem(input logic [15:0] ir);
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b10) return "MOVI";
    if (ir[15:13] == 3'b110 && ir[12:11] == 2'b00) return "MOV";
    if (ir[15:13] == 3'b101) begin
      case (ir[12:11])
        2'd0: return "ADD";
        2'd1: return "CMP";
        2'd2: return "AND";
        default: return "MVN";
      endcase
    end
    return "NOP";
  endfunction

  // Fields every cycle shows regardless of step.
  function automatic obs_t base(input logic [15:0] ir);
    obs_t o;
    o = '0;
    o.shift    = ir[4:3];
    o.aluop    = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    o.readnum  = ir[2:0];
    o.writenum = ir[7:5];
    o.sximm8   = 16'($signed(ir[7:0]));
    o.sximm5   = 16'($signed(ir[4:0]));
    return o;
  endfunction

  function automatic obs_t wait_out(input logic [15:0] ir);
    obs_t o;
    o = base(ir);
    o.w = 1'b1;
    return o;
  endfunction

  // Queue the expected busy cycles of one instruction.
  function automatic void build(input logic [15:0] ir);
    obs_t  b, c;
    string mn;
    b  = base(ir);
    mn = mnem(ir);
    exp_q.push_back(b);
    if (mn == "MOVI") begin
      c = b; c.vsel = 2'b10; c.writenum = ir[10:8]; c.write = 1'b1;
      exp_q.push_back(c);
    end else if (mn != "NOP") begin
      if (mn != "MOV" && mn != "MVN") begin
        c = b; c.readnum = ir[10:8]; c.loada = 1'b1;
        exp_q.push_back(c);
      end
      c = b; c.loadb = 1'b1;
      exp_q.push_back(c);
      c = b; c.loadc = 1'b1;
      c.loads = (mn == "CMP");
      c.asel  = (mn == "MOV");
      exp_q.push_back(c);
      if (mn != "CMP") begin
        c = b; c.writenum = ir[7:5]; c.write = 1'b1;
        exp_q.push_back(c);
      end
    end
  endfunction

  task automatic run_busy(output int busy, writes, wnum, aop,
                          lds, asl, lda);
    busy = 0; writes = 0; wnum = 0; aop = 0; lds = 0; asl = 0; lda = 0;
    while (!w && busy < 20) begin
      busy++;
      if (write) begin writes++; wnum = int'(writenum); end
      if (loadc) begin
        aop = int'(ALUop); lds = int'(loads); asl = int'(asel);
      end
      if (loada) lda++;
      tick;
    end
    if (!w) begin
      n_chk++; n_fail++;
      $display("FAIL busy_bound: w still %b after %0d cycles", w, busy);
    end
  endtask

  task automatic run_instr(input logic [15:0] ir, output int busy,
                           writes, wnum, aop, lds, asl, lda);
    in = ir; load = 1'b1; s = 1'b0;
    tick;
    load = 1'b0; s = 1'b1;
    tick;
    s = 1'b0;
    run_busy(busy, writes, wnum, aop, lds, asl, lda);
  endtask

  vec_t        vt[$];
  int          bz, wr, wn, ao, ls, al, la;
  logic [15:0] m_ir, r;
  logic        m_busy, l, st;
  obs_t        e;

  initial begin
    vt.push_back('{16'hD0FB, 2, 1, 0, 0, 0, 0, 0});
    vt.push_back('{16'hA148, 5, 1, 2, 0, 0, 0, 1});
    vt.push_back('{16'hA900, 4, 0, 0, 1, 1, 0, 1});
    vt.push_back('{16'hB2A5, 5, 1, 5, 2, 0, 0, 1});
    vt.push_back('{16'hC071, 4, 1, 3, 0, 0, 1, 0});
    vt.push_back('{16'hB881, 4, 1, 4, 3, 0, 0, 0});
    vt.push_back('{16'h0000, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{16'hD800, 1, 0, 0, 0, 0, 0, 0});
    vt.push_back('{16'h1234, 1, 0, 0, 0, 0, 0, 0});

    #12;
    check("reset_state", 64'(act), 64'(wait_out(16'h0)));
    rst_n = 1'b1;
    tick;
    check("post_reset", 64'(act), 64'(wait_out(16'h0)));

    foreach (vt[i]) begin
      run_instr(vt[i].ir, bz, wr, wn, ao, ls, al, la);
      check($sformatf("busy_%h", vt[i].ir), bz, vt[i].busy);
      check($sformatf("writes_%h", vt[i].ir), wr, vt[i].writes);
      check($sformatf("wnum_%h", vt[i].ir), wn, vt[i].wnum);
      check($sformatf("aluop_%h", vt[i].ir), ao, vt[i].aop);
      check($sformatf("loads_%h", vt[i].ir), ls, vt[i].lds);
      check($sformatf("asel_%h", vt[i].ir), al, vt[i].asl);
      check($sformatf("loada_%h", vt[i].ir), la, vt[i].lda);
    end

    // Reset while ADD sits in GET_B.
    in = 16'hA148; load = 1'b1;
    tick;
    load = 1'b0; s = 1'b1;
    tick;
    s = 1'b0;
    tick;
    tick;
    check("midadd_getb", loadb, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midadd_reset", 64'(act), 64'(wait_out(16'h0)));
    tick;
    check("midadd_hold", 64'(act), 64'(wait_out(16'h0)));
    rst_n = 1'b1; s = 1'b1;
    tick;
    s = 1'b0;
    check("nop_decode", 64'(act), 64'(base(16'h0)));
    tick;
    check("nop_back", 64'(act), 64'(wait_out(16'h0)));

    // load during a busy ADD must not touch the IR.
    in = 16'hA148; load = 1'b1;
    tick;
    load = 1'b0; s = 1'b1;
    tick;
    s = 1'b0; in = 16'hD0FB; load = 1'b1;
    run_busy(bz, wr, wn, ao, ls, al, la);
    load = 1'b0;
    check("busyload_busy", bz, 5);
    check("busyload_wnum", wn, 2);
    check("busyload_ir", sximm8, 16'h0048);

    // load and s on the same edge: DECODE sees the new word.
    in = 16'hD0FB; load = 1'b1; s = 1'b1;
    tick;
    load = 1'b0; s = 1'b0;
    check("ls_decode", 64'(act), 64'(base(16'hD0FB)));
    tick;
    check("ls_write", {write, vsel, writenum}, {1'b1, 2'b10, 3'd0});
    check("ls_imm", sximm8, 16'hFFFB);
    tick;
    check("ls_done", w, 1'b1);

    // s held high relaunches immediately after completion.
    s = 1'b1;
    tick;
    tick;
    tick;
    check("shold_wait", w, 1'b1);
    tick;
    check("shold_relaunch", w, 1'b0);
    s = 1'b0;
    tick;
    tick;
    check("shold_end", w, 1'b1);

    // Random run against the cycle script model.
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_ir = '0; m_busy = 1'b0; exp_q.delete();
    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      case ($urandom % 4)
        0, 1: r[15:13] = 3'b101;
        2:    r[15:13] = 3'b110;
        default: ;
      endcase
      l  = (($urandom % 4) == 0);
      st = (($urandom % 3) == 0);
      in = r; load = l; s = st;
      if (!m_busy) begin
        if (l) m_ir = r;
        if (st) build(m_ir);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_busy = 1'b1;
      end else begin
        e = wait_out(m_ir);
        m_busy = 1'b0;
      end
      tick;
      check($sformatf("rand_%0d", i), 64'(act), 64'(e));
    end
    load = 1'b0; s = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
